fb_read_arbiter: RTL and testbench
==================================

Name: fb_read_arbiter

Overview:
- Shares the single synchronous read port of one 320x240 8-bit frame buffer between two requesters.
- Requester 0 is the display path: VGA pixel fetch, single-word requests, strict priority.
- Requester 1 is the stereo matcher: SAD/census line-segment bursts, serviced in the background.
- Sits between the frame buffer read side and the display/matcher logic; one instance per frame buffer (left and right).

Parameters:
- ADDR_W, 17, frame buffer address width
- DATA_W, 8, pixel width
- FB_DEPTH, 76800, number of frame buffer words (320*240); burst addresses wrap modulo this value
- LEN_W, 9, burst length width (1..320 pixels)
- MAX_STALL, 4, consecutive display grants before a pending burst is forced one slot (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  display read request, sampled every cycle
- disp_addr  in  ADDR_W  display read address
- disp_ack  out  1  display request issued to the frame buffer this cycle
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid
- mat_start  in  1  one-cycle pulse to start a burst; accepted only when mat_busy=0
- mat_base  in  ADDR_W  burst start address, sampled with mat_start
- mat_len  in  LEN_W  burst length, sampled with mat_start; 0 is ignored
- mat_busy  out  1  burst in progress
- mat_rdata  out  DATA_W  burst read data, returned in address order
- mat_rvalid  out  1  mat_rdata valid
- mat_done  out  1  one-cycle pulse, coincident with the last mat_rvalid of a burst
- fb_oe  out  1  frame buffer read enable
- fb_rAddr  out  ADDR_W  frame buffer read address
- fb_rData  in  DATA_W  frame buffer read data, valid one clk after fb_oe

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All outputs go to 0, FSM goes to IDLE, counters clear.
  - In-flight tags are cleared, so no rvalid occurs after reset even if a read was issued the cycle before.
- Issue: fb_oe and fb_rAddr are combinational from the grant decision. At most one read is issued per cycle.
- Latency:
  - Cycle t: issue. Cycle t+1: fb_rData returns and the owner tag is registered. Cycle t+2: registered rdata/rvalid appear on the owner's port.
  - Accept-to-rvalid is fixed at 2 cycles for both requesters.
- Grant rule: if disp_req=1, display wins; disp_ack=1, fb_rAddr=disp_addr. Otherwise, if FSM=RUN, the burst issues the next address.
- A display-only request while in IDLE is issued normally.
- FSM:
  - IDLE -> RUN on mat_start with mat_len!=0. Latches base and len, sets mat_busy=1 the next cycle. mat_start with mat_len=0 is ignored.
  - RUN issues base+i, i = 0..len-1. Address wraps from FB_DEPTH-1 to 0; the sum is never reduced by masking.
  - i advances only on cycles where the burst wins the port. Display grants stall the burst with no data loss.
  - RUN -> DRAIN on the cycle the last address issues.
  - DRAIN -> IDLE when the last burst word's mat_rvalid is output. mat_done=1 in that same cycle; mat_busy falls on the following cycle.
- mat_start while mat_busy=1 is ignored, with no effect on the running burst.
- disp_req and mat_start in the same cycle while in IDLE: display is issued and the burst is latched; the burst's first issue can occur the next cycle.
- mat_rvalid count per burst equals len exactly. Data order equals address order.

Optional Feature:
- Macro: FB_ARB_FAIR_SHARE_EN.
- Defined:
  - A stall counter increments on each display grant while FSM=RUN and resets on each burst issue.
  - When the counter reaches MAX_STALL, the next cycle grants the burst even if disp_req=1. disp_ack=0 that cycle and the display must hold its request.
- Undefined: strict display priority; a burst may starve indefinitely.

Decomposition:
- Package fb_arb_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - owner tag enum {OWN_NONE, OWN_DISP, OWN_MAT}
  - FB_DEPTH/ADDR_W defaults
- One sub-module, fb_burst_addr_gen, provides the base/len latch, index counter, modulo-FB_DEPTH address, and last-issue flag.

Test Plan:
- Display only: disp_req=1 with addresses 0,1,2 over 3 cycles -> disp_ack=1 each cycle, disp_rvalid at cycles +2..+4 with mem[0..2], mat_rvalid never asserted.
- Burst alone: mat_start, base=100, len=5 -> fb_rAddr 100..104 on 5 consecutive cycles, mat_rvalid 5 cycles, mat_done on the 5th, mat_busy low the next cycle.
- Preemption: burst base=0, len=4, disp_req asserted during the 2nd and 3rd burst slots -> burst addresses 0,1 then a 2-cycle stall then 2,3. Display data goes to the display port; mat_rdata order is 0,1,2,3.
- Wrap and ignore: base=76798, len=4 -> addresses 76798,76799,0,1. A second mat_start mid-burst and a start with mat_len=0 in IDLE both have no effect.
- Reset mid-burst: reset asserted one cycle after the 2nd issue of a len=10 burst -> no rvalid afterward, mat_busy=0, and a new burst runs correctly afterward.
- FB_ARB_FAIR_SHARE_EN with MAX_STALL=4: continuous disp_req during a len=2 burst -> disp_ack pattern 1,1,1,1,0 repeating; burst completes within 10 cycles.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared types and default sizes for the frame buffer read arbiter.
//   arb_state_e : burst FSM states (IDLE, RUN, DRAIN)
//   owner_e     : tag recording which requester owns an in-flight read
package fb_arb_pkg;

  localparam int unsigned FB_DEPTH_DEF = 76800;  // 320 x 240 pixels
  localparam int unsigned ADDR_W_DEF   = 17;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_MAT
  } owner_e;

endpackage

// File: rtl/fb_burst_addr_gen.sv
// fb_burst_addr_gen: burst address sequencer for the matcher requester.
//   load_i       : latch base_i/len_i and restart the sequence
//   adv_i        : the current address was issued; step to the next one
//   addr_o       : address to issue, wraps from FB_DEPTH-1 back to 0
//   last_o       : addr_o is the final address of the burst
module fb_burst_addr_gen #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned LEN_W    = 9,
  parameter int unsigned FB_DEPTH = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;

  // Address is stepped incrementally with an explicit wrap compare, so the
  // depth does not have to be a power of two.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = base_i;
      remain_d = len_i;
    end else if (adv_i) begin
      addr_d   = (addr_q == ADDR_W'(FB_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
      remain_d = remain_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == LEN_W'(1));

endmodule

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares one synchronous frame buffer read port between the
// display fetch (strict priority, single words) and the stereo matcher
// (background bursts). Read data returns two cycles after issue on the
// owner's port.
//   disp_*  : display requester (req/addr in, ack/rdata/rvalid out)
//   mat_*   : matcher burst (start/base/len in, busy/rdata/rvalid/done out)
//   fb_*    : frame buffer read port (oe/rAddr out, rData in, 1-cycle latency)
// Optional build macro FB_ARB_FAIR_SHARE_EN: after MAX_STALL consecutive
// display grants during a burst, one slot is forced to the burst.
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FB_DEPTH = FB_DEPTH_DEF,
  parameter int unsigned LEN_W    = 9
`ifdef FB_ARB_FAIR_SHARE_EN
  ,
  parameter int unsigned MAX_STALL = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              mat_start,
  input  logic [ADDR_W-1:0] mat_base,
  input  logic [LEN_W-1:0]  mat_len,
  output logic              mat_busy,
  output logic [DATA_W-1:0] mat_rdata,
  output logic              mat_rvalid,
  output logic              mat_done,
  output logic              fb_oe,
  output logic [ADDR_W-1:0] fb_rAddr,
  input  logic [DATA_W-1:0] fb_rData
);

  arb_state_e        state_q, state_d;
  owner_e            tag_q, tag_d;
  logic              last_q;
  logic              disp_go, burst_go, force_burst, load;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_last;

  logic [DATA_W-1:0] disp_rdata_q, mat_rdata_q;
  logic              disp_rvalid_q, mat_rvalid_q, mat_done_q;

`ifdef FB_ARB_FAIR_SHARE_EN
  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  assign force_burst = (state_q == RUN) && (stall_q == STALL_W'(MAX_STALL));

  always_comb begin
    stall_d = '0;
    if (state_q == RUN) begin
      if (burst_go)     stall_d = '0;
      else if (disp_go) stall_d = stall_q + STALL_W'(1);
      else              stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign force_burst = 1'b0;
`endif

  fb_burst_addr_gen #(
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .FB_DEPTH(FB_DEPTH)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load_i(load),
    .base_i(mat_base),
    .len_i (mat_len),
    .adv_i (burst_go),
    .addr_o(burst_addr),
    .last_o(burst_last)
  );

  always_comb begin
    disp_go  = disp_req && !force_burst;
    burst_go = (state_q == RUN) && !disp_go;
    load     = 1'b0;
    state_d  = state_q;
    tag_d    = OWN_NONE;
    fb_oe    = disp_go || burst_go;
    fb_rAddr = '0;
    if (disp_go) begin
      fb_rAddr = disp_addr;
      tag_d    = OWN_DISP;
    end else if (burst_go) begin
      fb_rAddr = burst_addr;
      tag_d    = OWN_MAT;
    end
    unique case (state_q)
      IDLE: if (mat_start && (mat_len != '0)) begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN:   if (burst_go && burst_last) state_d = DRAIN;
      // mat_done_q marks the cycle the final burst word is on mat_rdata.
      DRAIN: if (mat_done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tag_q         <= OWN_NONE;
      last_q        <= 1'b0;
      disp_rdata_q  <= '0;
      disp_rvalid_q <= 1'b0;
      mat_rdata_q   <= '0;
      mat_rvalid_q  <= 1'b0;
      mat_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      last_q        <= burst_go && burst_last;
      disp_rvalid_q <= (tag_q == OWN_DISP);
      mat_rvalid_q  <= (tag_q == OWN_MAT);
      mat_done_q    <= (tag_q == OWN_MAT) && last_q;
      if (tag_q == OWN_DISP) disp_rdata_q <= fb_rData;
      if (tag_q == OWN_MAT)  mat_rdata_q  <= fb_rData;
    end
  end

  assign disp_ack    = disp_go;
  assign disp_rdata  = disp_rdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign mat_rdata   = mat_rdata_q;
  assign mat_rvalid  = mat_rvalid_q;
  assign mat_done    = mat_done_q;
  assign mat_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed testbench for fb_read_arbiter. The frame buffer is modelled as a
// one-cycle-latency read of a fixed address-derived pixel pattern.
module tb_fb_read_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 9;
  localparam int unsigned DEPTH = 76800;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          mat_start;
  logic [AW-1:0] mat_base;
  logic [LW-1:0] mat_len;
  logic          mat_busy;
  logic [DW-1:0] mat_rdata;
  logic          mat_rvalid;
  logic          mat_done;
  logic          fb_oe;
  logic [AW-1:0] fb_rAddr;
  logic [DW-1:0] fb_rData = '0;

  int total = 0;
  int bad = 0;

  fb_read_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_ack   (disp_ack),
    .disp_rdata (disp_rdata),
    .disp_rvalid(disp_rvalid),
    .mat_start  (mat_start),
    .mat_base   (mat_base),
    .mat_len    (mat_len),
    .mat_busy   (mat_busy),
    .mat_rdata  (mat_rdata),
    .mat_rvalid (mat_rvalid),
    .mat_done   (mat_done),
    .fb_oe      (fb_oe),
    .fb_rAddr   (fb_rAddr),
    .fb_rData   (fb_rData)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int unsigned a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ {7'd0, v[16]} ^ 8'h3C;
  endfunction

  always @(posedge clk) if (fb_oe) fb_rData <= pix(32'(fb_rAddr));

  // Inputs change 1ns after the edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = '0;
    mat_start = 1'b0; mat_base = '0; mat_len = '0;
  endtask

  task automatic flush();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step(); step();
    #1;
    total++;
    if ({fb_oe, disp_ack, disp_rvalid, mat_busy, mat_rvalid, mat_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {fb_oe, disp_ack, disp_rvalid, mat_busy, mat_rvalid, mat_done});
    end
    total++;
    if ({disp_rdata, mat_rdata} !== 16'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0000", {disp_rdata, mat_rdata});
    end
    reset = 1'b0;
  endtask

  task automatic test_display();
    for (int c = 0; c < 6; c++) begin
      step();
      disp_req  = (c < 3);
      disp_addr = AW'(c);
      #1;
      total++;
      if (disp_ack !== (c < 3)) begin
        bad++; $display("FAIL disp_ack c=%0d got=%b exp=%b", c, disp_ack, (c < 3));
      end
      total++;
      if (fb_oe !== (c < 3)) begin
        bad++; $display("FAIL disp_oe c=%0d got=%b exp=%b", c, fb_oe, (c < 3));
      end
      if (c < 3) begin
        total++;
        if (fb_rAddr !== AW'(c)) begin
          bad++; $display("FAIL disp_addr c=%0d got=%0d exp=%0d", c, fb_rAddr, c);
        end
      end
      total++;
      if (disp_rvalid !== (c >= 2 && c <= 4)) begin
        bad++; $display("FAIL disp_rvalid c=%0d got=%b exp=%b", c, disp_rvalid, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        total++;
        if (disp_rdata !== pix(c - 2)) begin
          bad++; $display("FAIL disp_rdata c=%0d got=%h exp=%h", c, disp_rdata, pix(c - 2));
        end
      end
      total++;
      if (mat_rvalid !== 1'b0) begin
        bad++; $display("FAIL disp_mat_rvalid c=%0d got=%b exp=0", c, mat_rvalid);
      end
    end
    idle_inputs();
  endtask

  // Uninterrupted burst: issues on cycles 1..len, data on 3..len+2.
  task automatic test_burst(input int base, input int len);
    int nv = 0;
    for (int c = 0; c <= len + 3; c++) begin
      step();
      mat_start = (c == 0);
      mat_base  = AW'(base);
      mat_len   = LW'(len);
      #1;
      total++;
      if (fb_oe !== (c >= 1 && c <= len)) begin
        bad++; $display("FAIL burst_oe c=%0d got=%b exp=%b", c, fb_oe, (c >= 1 && c <= len));
      end
      if (c >= 1 && c <= len) begin
        total++;
        if (fb_rAddr !== AW'((base + c - 1) % DEPTH)) begin
          bad++; $display("FAIL burst_addr c=%0d got=%0d exp=%0d", c, fb_rAddr, (base + c - 1) % DEPTH);
        end
      end
      total++;
      if (mat_rvalid !== (c >= 3 && c <= len + 2)) begin
        bad++; $display("FAIL burst_rvalid c=%0d got=%b exp=%b", c, mat_rvalid, (c >= 3 && c <= len + 2));
      end
      if (mat_rvalid === 1'b1) nv++;
      if (c >= 3 && c <= len + 2) begin
        total++;
        if (mat_rdata !== pix((base + c - 3) % DEPTH)) begin
          bad++; $display("FAIL burst_rdata c=%0d got=%h exp=%h", c, mat_rdata, pix((base + c - 3) % DEPTH));
        end
      end
      total++;
      if (mat_done !== (c == len + 2)) begin
        bad++; $display("FAIL burst_done c=%0d got=%b exp=%b", c, mat_done, (c == len + 2));
      end
      total++;
      if (mat_busy !== (c >= 1 && c <= len + 2)) begin
        bad++; $display("FAIL burst_busy c=%0d got=%b exp=%b", c, mat_busy, (c >= 1 && c <= len + 2));
      end
    end
    total++;
    if (nv != len) begin
      bad++; $display("FAIL burst_count got=%0d exp=%0d", nv, len);
    end
    idle_inputs();
  endtask

  // Display at c0 (with the start) and c3,c4 preempts burst base 0 len 4.
  task automatic test_preempt();
    int ea[10]   = '{10, 0, 1, 13, 14, 2, 3, -1, -1, -1};
    int eack[10] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    int em[10]   = '{-1, -1, -1, 0, 1, -1, -1, 2, 3, -1};
    int ed[10]   = '{-1, -1, 10, -1, -1, 13, 14, -1, -1, -1};
    int done_c = 8;
    for (int c = 0; c < 10; c++) begin
      step();
      mat_start = (c == 0); mat_base = '0; mat_len = LW'(4);
      disp_req  = (c == 0 || c == 3 || c == 4); disp_addr = AW'(10 + c);
      #1;
      total++;
      if (fb_oe !== (ea[c] >= 0)) begin
        bad++; $display("FAIL pre_oe c=%0d got=%b exp=%b", c, fb_oe, (ea[c] >= 0));
      end
      if (ea[c] >= 0) begin
        total++;
        if (fb_rAddr !== AW'(ea[c])) begin
          bad++; $display("FAIL pre_addr c=%0d got=%0d exp=%0d", c, fb_rAddr, ea[c]);
        end
      end
      total++;
      if (disp_ack !== eack[c][0]) begin
        bad++; $display("FAIL pre_ack c=%0d got=%b exp=%0d", c, disp_ack, eack[c]);
      end
      total++;
      if (mat_rvalid !== (em[c] >= 0)) begin
        bad++; $display("FAIL pre_mvalid c=%0d got=%b exp=%b", c, mat_rvalid, (em[c] >= 0));
      end
      if (em[c] >= 0) begin
        total++;
        if (mat_rdata !== pix(em[c])) begin
          bad++; $display("FAIL pre_mdata c=%0d got=%h exp=%h", c, mat_rdata, pix(em[c]));
        end
      end
      total++;
      if (disp_rvalid !== (ed[c] >= 0)) begin
        bad++; $display("FAIL pre_dvalid c=%0d got=%b exp=%b", c, disp_rvalid, (ed[c] >= 0));
      end
      if (ed[c] >= 0) begin
        total++;
        if (disp_rdata !== pix(ed[c])) begin
          bad++; $display("FAIL pre_ddata c=%0d got=%h exp=%h", c, disp_rdata, pix(ed[c]));
        end
      end
      total++;
      if (mat_done !== (c == done_c)) begin
        bad++; $display("FAIL pre_done c=%0d got=%b exp=%b", c, mat_done, (c == done_c));
      end
      total++;
      if (mat_busy !== (c >= 1 && c <= done_c)) begin
        bad++; $display("FAIL pre_busy c=%0d got=%b exp=%b", c, mat_busy, (c >= 1 && c <= done_c));
      end
    end
    idle_inputs();
  endtask

  // Burst wrapping past the last pixel; a mid-burst start and a zero-length
  // start in IDLE must both be ignored.
  task automatic test_wrap();
    int ea[10] = '{-1, 76798, 76799, 0, 1, -1, -1, -1, -1, -1};
    int em[10] = '{-1, -1, -1, 76798, 76799, 0, 1, -1, -1, -1};
    int done_c = 6;
    for (int c = 0; c < 10; c++) begin
      step();
      mat_start = (c == 0 || c == 2 || c == 8);
      mat_base  = (c == 0) ? AW'(76798) : AW'(5 + c);
      mat_len   = (c == 0) ? LW'(4) : (c == 2) ? LW'(3) : LW'(0);
      #1;
      total++;
      if (fb_oe !== (ea[c] >= 0)) begin
        bad++; $display("FAIL wrap_oe c=%0d got=%b exp=%b", c, fb_oe, (ea[c] >= 0));
      end
      if (ea[c] >= 0) begin
        total++;
        if (fb_rAddr !== AW'(ea[c])) begin
          bad++; $display("FAIL wrap_addr c=%0d got=%0d exp=%0d", c, fb_rAddr, ea[c]);
        end
      end
      total++;
      if (mat_rvalid !== (em[c] >= 0)) begin
        bad++; $display("FAIL wrap_mvalid c=%0d got=%b exp=%b", c, mat_rvalid, (em[c] >= 0));
      end
      if (em[c] >= 0) begin
        total++;
        if (mat_rdata !== pix(em[c])) begin
          bad++; $display("FAIL wrap_mdata c=%0d got=%h exp=%h", c, mat_rdata, pix(em[c]));
        end
      end
      total++;
      if (mat_done !== (c == done_c)) begin
        bad++; $display("FAIL wrap_done c=%0d got=%b exp=%b", c, mat_done, (c == done_c));
      end
      total++;
      if (mat_busy !== (c >= 1 && c <= done_c)) begin
        bad++; $display("FAIL wrap_busy c=%0d got=%b exp=%b", c, mat_busy, (c >= 1 && c <= done_c));
      end
    end
    idle_inputs();
  endtask

  // Reset one cycle after the 2nd issue of a len=10 burst; nothing may
  // emerge afterwards, then a fresh burst must run normally.
  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      step();
      mat_start = (c == 0); mat_base = AW'(200); mat_len = LW'(10);
      reset = (c == 3);
      #1;
      if (c >= 1 && c <= 3) begin
        total++;
        if (fb_rAddr !== AW'(199 + c)) begin
          bad++; $display("FAIL rmid_addr c=%0d got=%0d exp=%0d", c, fb_rAddr, 199 + c);
        end
      end
      if (c >= 4) begin
        total++;
        if ({fb_oe, mat_busy, mat_rvalid, mat_done, disp_rvalid} !== 5'b0) begin
          bad++;
          $display("FAIL rmid_quiet c=%0d got=%b exp=00000", c,
                   {fb_oe, mat_busy, mat_rvalid, mat_done, disp_rvalid});
        end
      end
    end
    reset = 1'b0;
    idle_inputs();
    test_burst(300, 3);
  endtask

`ifdef FB_ARB_FAIR_SHARE_EN
  // Continuous display traffic with MAX_STALL=4: ack pattern 1,1,1,1,0.
  task automatic test_fair();
    int ea[14]   = '{10, 11, 12, 13, 14, 1000, 16, 17, 18, 19, 1001, 21, -1, -1};
    int eack[14] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0};
    int em[14]   = '{-1, -1, -1, -1, -1, -1, -1, 1000, -1, -1, -1, -1, 1001, -1};
    int ed[14]   = '{-1, -1, 10, 11, 12, 13, 14, -1, 16, 17, 18, 19, -1, 21};
    int done_c = 12;
    for (int c = 0; c < 14; c++) begin
      step();
      mat_start = (c == 0); mat_base = AW'(1000); mat_len = LW'(2);
      disp_req  = (c <= 11); disp_addr = AW'(10 + c);
`else
  // Strict priority: a burst waits as long as the display keeps requesting.
  task automatic test_starve();
    int ea[14]   = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 1000, 1001, -1, -1, -1};
    int eack[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int em[14]   = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 1000, 1001, -1};
    int ed[14]   = '{-1, -1, 10, 11, 12, 13, 14, 15, 16, 17, 18, -1, -1, -1};
    int done_c = 12;
    for (int c = 0; c < 14; c++) begin
      step();
      mat_start = (c == 0); mat_base = AW'(1000); mat_len = LW'(2);
      disp_req  = (c <= 8); disp_addr = AW'(10 + c);
`endif
      #1;
      total++;
      if (fb_oe !== (ea[c] >= 0)) begin
        bad++; $display("FAIL share_oe c=%0d got=%b exp=%b", c, fb_oe, (ea[c] >= 0));
      end
      if (ea[c] >= 0) begin
        total++;
        if (fb_rAddr !== AW'(ea[c])) begin
          bad++; $display("FAIL share_addr c=%0d got=%0d exp=%0d", c, fb_rAddr, ea[c]);
        end
      end
      total++;
      if (disp_ack !== eack[c][0]) begin
        bad++; $display("FAIL share_ack c=%0d got=%b exp=%0d", c, disp_ack, eack[c]);
      end
      total++;
      if (mat_rvalid !== (em[c] >= 0)) begin
        bad++; $display("FAIL share_mvalid c=%0d got=%b exp=%b", c, mat_rvalid, (em[c] >= 0));
      end
      if (em[c] >= 0) begin
        total++;
        if (mat_rdata !== pix(em[c])) begin
          bad++; $display("FAIL share_mdata c=%0d got=%h exp=%h", c, mat_rdata, pix(em[c]));
        end
      end
      total++;
      if (disp_rvalid !== (ed[c] >= 0)) begin
        bad++; $display("FAIL share_dvalid c=%0d got=%b exp=%b", c, disp_rvalid, (ed[c] >= 0));
      end
      if (ed[c] >= 0) begin
        total++;
        if (disp_rdata !== pix(ed[c])) begin
          bad++; $display("FAIL share_ddata c=%0d got=%h exp=%h", c, disp_rdata, pix(ed[c]));
        end
      end
      total++;
      if (mat_done !== (c == done_c)) begin
        bad++; $display("FAIL share_done c=%0d got=%b exp=%b", c, mat_done, (c == done_c));
      end
      total++;
      if (mat_busy !== (c >= 1 && c <= done_c)) begin
        bad++; $display("FAIL share_busy c=%0d got=%b exp=%b", c, mat_busy, (c >= 1 && c <= done_c));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_display();
    flush();
    test_burst(100, 5);
    flush();
    test_preempt();
    flush();
    test_wrap();
    flush();
    test_reset_mid();
    flush();
`ifdef FB_ARB_FAIR_SHARE_EN
    test_fair();
`else
    test_starve();
`endif
    flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
